bcd_chain_counter: RTL and testbench

BCD_CHAIN_COUNTER -- requirements
Module: bcd_chain_counter

---
 rtl/bcd_chain_counter_pkg.sv | 11 +
 rtl/bcd_digit.sv | 35 +++
 rtl/bcd_chain_counter.sv | 64 ++++++
 tb/tb_bcd_chain_counter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/bcd_chain_counter_pkg.sv
// Shared constants for BCD counter chains (digit width, default 00..59 limit)
// and the per-digit load clamp.
package bcd_chain_counter_pkg;
  localparam int BCD_W = 4;
  localparam logic [7:0] DIGIT_MAX_DEFAULT = 8'h59;

  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] v,
                                                 input logic [BCD_W-1:0] mx);
    return (v > mx) ? mx : v;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// One BCD digit with a programmable maximum. It steps only when carry_in is high,
// and it passes a carry or a borrow on to the next digit.
module bcd_digit
  import bcd_chain_counter_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [BCD_W-1:0] value,
  input  logic [BCD_W-1:0] max,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic             carry_in,
  output logic             carry_out,
  output logic [BCD_W-1:0] count
);
  logic at_max, at_zero;

  assign at_max    = (count == max);
  assign at_zero   = (count == '0);
  assign carry_out = carry_in & ((inc & at_max) | (dec & at_zero));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      count <= '0;
    else if (load)
      count <= bcd_clamp(value, max);
    else if (carry_in) begin
      if (inc)
        count <= at_max ? '0 : count + 4'd1;
      else if (dec)
        count <= at_zero ? max : count - 4'd1;
    end
  end
endmodule

// File: rtl/bcd_chain_counter.sv
// Cascaded BCD up/down counter. A step fires on each rising edge of en_i, and a load
// takes priority over a step. en_o pulses once on wrap or saturation.
module bcd_chain_counter
  import bcd_chain_counter_pkg::*;
#(
  parameter int                       DIGITS    = 2,
  parameter logic [BCD_W*DIGITS-1:0]  DIGIT_MAX = DIGIT_MAX_DEFAULT,
  parameter bit                       WRAP      = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  input  logic                    dir_i,
  input  logic                    set_value_i,
  input  logic [BCD_W*DIGITS-1:0] value_i,
  output logic [BCD_W*DIGITS-1:0] count_o,
  output logic                    en_o,
  output logic                    zero_o
);
  logic            en_q, step, at_term, all_max, all_zero, term_evt;
  logic [DIGITS:0] carry;

  // en_q resets high so that en_i already high at reset release does not step
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      en_q <= 1'b1;
      en_o <= 1'b0;
    end else begin
      en_q <= en_i;
      en_o <= term_evt;
    end
  end

  always_comb begin
    all_max  = 1'b1;
    all_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (count_o[k*BCD_W +: BCD_W] != DIGIT_MAX[k*BCD_W +: BCD_W]) all_max  = 1'b0;
      if (count_o[k*BCD_W +: BCD_W] != '0)                          all_zero = 1'b0;
    end
  end

  assign step     = en_i & ~en_q & ~set_value_i;
  assign at_term  = dir_i ? all_max : all_zero;
  // In saturate mode the chain gets no step at the terminal count, so it holds
  assign carry[0] = step & (WRAP | ~at_term);
  assign term_evt = WRAP ? carry[DIGITS] : (step & at_term);
  assign zero_o   = all_zero;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .value     (value_i[g*BCD_W +: BCD_W]),
      .max       (DIGIT_MAX[g*BCD_W +: BCD_W]),
      .inc       (dir_i),
      .dec       (~dir_i),
      .load      (set_value_i),
      .carry_in  (carry[g]),
      .carry_out (carry[g+1]),
      .count     (count_o[g*BCD_W +: BCD_W])
    );
  end
endmodule

// File: tb/tb_bcd_chain_counter.sv
// Bench for bcd_chain_counter: a wrapping and a saturating instance share the same stimulus
// and are scored against a decimal 0..59 model through a queue of expected results.
module tb_bcd_chain_counter;
  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       en_i, dir_i, set_value_i;
  logic [7:0] value_i;
  logic [7:0] count_w, count_s;
  logic       en_w, en_s, zero_w, zero_s;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] cw;
    logic       ew;
    logic [7:0] cs;
    logic       es;
  } exp_t;
  exp_t sb[$];

  int mw, ms;
  bit menq;

  always #5 clk_i = ~clk_i;

  bcd_chain_counter #(.DIGITS(2), .DIGIT_MAX(8'h59), .WRAP(1'b1)) dut_w (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .dir_i(dir_i),
    .set_value_i(set_value_i), .value_i(value_i),
    .count_o(count_w), .en_o(en_w), .zero_o(zero_w));

  bcd_chain_counter #(.DIGITS(2), .DIGIT_MAX(8'h59), .WRAP(1'b0)) dut_s (
    .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i), .dir_i(dir_i),
    .set_value_i(set_value_i), .value_i(value_i),
    .count_o(count_s), .en_o(en_s), .zero_o(zero_s));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] h, l;
    h = 4'(v / 10);
    l = 4'(v % 10);
    return {h, l};
  endfunction

  function automatic int clamp_int(input logic [7:0] v);
    int h, l;
    h = (v[7:4] > 4'd5) ? 5 : int'(v[7:4]);
    l = (v[3:0] > 4'd9) ? 9 : int'(v[3:0]);
    return h * 10 + l;
  endfunction

  // Drive one cycle, predict both instances, then score after the edge
  task automatic cyc(input bit en, input bit dir, input bit set, input logic [7:0] val);
    exp_t e;
    bit   stp;
    en_i = en; dir_i = dir; set_value_i = set; value_i = val;
    stp  = en && !menq && !set;
    e.ew = 1'b0;
    e.es = 1'b0;
    if (set) begin
      mw = clamp_int(val);
      ms = mw;
    end else if (stp) begin
      if (dir) begin
        e.ew = (mw == 59); mw = (mw == 59) ? 0 : mw + 1;
        e.es = (ms == 59); ms = (ms == 59) ? 59 : ms + 1;
      end else begin
        e.ew = (mw == 0); mw = (mw == 0) ? 59 : mw - 1;
        e.es = (ms == 0); ms = (ms == 0) ? 0 : ms - 1;
      end
    end
    menq = en;
    e.cw = to_bcd(mw);
    e.cs = to_bcd(ms);
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    chk("count_w", 32'(count_w), 32'(e.cw));
    chk("en_o_w",  32'(en_w),    32'(e.ew));
    chk("zero_w",  32'(zero_w),  32'(e.cw == 8'h00));
    chk("count_s", 32'(count_s), 32'(e.cs));
    chk("en_o_s",  32'(en_s),    32'(e.es));
    chk("zero_s",  32'(zero_s),  32'(e.cs == 8'h00));
  endtask

  // Assert reset between edges, check it takes effect at once, release with en_i high
  task automatic do_reset();
    #2 reset_i = 1'b1;
    #1;
    chk("rst_count", 32'(count_w), 32'h00);
    chk("rst_en_o",  32'(en_w),    32'h0);
    chk("rst_zero",  32'(zero_w),  32'h1);
    en_i = 1'b1; dir_i = 1'b1; set_value_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0;
    mw = 0; ms = 0; menq = 1'b1;
  endtask

  initial begin
    reset_i = 1'b1; en_i = 1'b0; dir_i = 1'b1; set_value_i = 1'b0; value_i = 8'h00;
    mw = 0; ms = 0; menq = 1'b1;
    #22 reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    menq = 1'b0;
    chk("init_count", 32'(count_w), 32'h00);
    chk("init_en_o",  32'(en_w),    32'h0);
    chk("init_zero",  32'(zero_w),  32'h1);

    // up wrap / saturate at 59
    cyc(0, 1, 1, 8'h59);
    cyc(1, 1, 0, 8'h00);
    cyc(1, 1, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);
    // down borrow at 00
    cyc(0, 0, 1, 8'h00);
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    // plain down step with decade borrow
    cyc(0, 0, 1, 8'h30);
    cyc(1, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    // held enable steps once
    cyc(0, 1, 1, 8'h36);
    repeat (5) cyc(1, 1, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);
    cyc(1, 1, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);
    // clamp and load-over-step priority
    cyc(1, 1, 1, 8'h7C);
    repeat (3) cyc(1, 1, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);
    // mixed traffic
    for (int i = 0; i < 80; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 7) == 0), 8'($urandom));
    // reset mid-operation at 37, then at an en_o pulse
    cyc(0, 1, 1, 8'h37);
    do_reset();
    cyc(1, 1, 0, 8'h00);
    cyc(0, 1, 0, 8'h00);
    cyc(1, 1, 0, 8'h00);
    cyc(0, 1, 1, 8'h59);
    cyc(1, 1, 0, 8'h00);
    do_reset();
    cyc(1, 0, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
